div_iter_param: RTL
===================

# div_iter_param

Parametrised iterative radix-2 integer divider that generalises the fixed 32-bit signed/unsigned divider to any operand width. It latches operands internally and has a ready/valid handshake. RISC-V M-extension corner cases (divide-by-zero, signed overflow) are handled inside the block. It sits behind the ALU/execute stage and serves DIV/DIVU/REM/REMU (and the W variants when instantiated with WIDTH=32 on a 64-bit core).

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge where ready=1.
- is_signed  in  1  operands and results are two's complement when 1, unsigned when 0; sampled with start.
- dividend  in  WIDTH  dividend; sampled with start.
- divisor  in  WIDTH  divisor; sampled with start.
- ready  out  1  block can accept start (state IDLE or DONE).
- valid  out  1  one-cycle pulse; quotient, remainder and error are valid.
- error  out  1  divisor was zero; meaningful while valid=1 and held with the result.
- quotient  out  WIDTH  quotient, registered.
- remainder  out  WIDTH  remainder, registered; sign follows the dividend.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE.
- Reset values: ready=1, valid=0, error=0, quotient=0, remainder=0, internal counter=0.
- IDLE/DONE + start: latch operand magnitudes (negate when is_signed and operand MSB=1), latch q_neg = is_signed & (sign(dividend) ≠ sign(divisor)) & divisor≠0, latch r_neg = is_signed & sign(dividend), latch div_zero = (divisor==0). Go to CALC with counter=WIDTH-1.
- The magnitude of the most-negative value is 2^(WIDTH-1), treated as an unsigned WIDTH-bit value.
- CALC: one restoring step per cycle. Shift {rem, quo} left by one, trial-subtract the divisor magnitude from the WIDTH+1-bit partial remainder, and set the quo LSB on no-borrow. When counter=0, register the sign-corrected results (two's-complement negate under q_neg/r_neg) into quotient/remainder and error←div_zero, then go to DONE. Otherwise decrement the counter.
- DONE: valid=1 for this cycle only. Go to IDLE, or to CALC/DONE if start is accepted in this cycle (back-to-back).
- Outputs hold their last result until the next result is written. They are never cleared by start.
- start while in CALC is ignored; there is no queueing.
- Divide-by-zero: quotient = all ones (-1), remainder = dividend, error=1. Applies to signed and unsigned. The restoring datapath produces these values naturally.
- Signed overflow (dividend = -2^(WIDTH-1), divisor = -1): quotient = -2^(WIDTH-1), remainder = 0, error=0.
- Reset asserted mid-operation: immediate return to IDLE. valid is not pulsed and outputs return to reset values.

## Timing
- Normal latency: start accepted at edge t. CALC occupies WIDTH cycles. valid=1 in cycle t+WIDTH+1.
- Throughput: one division per WIDTH+1 cycles when start is held high.
- ready is combinational from state (ready = state≠CALC). Operands need only be stable on the accepting edge.

## Configuration
- DIV_FASTPATH_EN defined:
  - Divide-by-zero and signed-overflow requests bypass CALC and go straight IDLE/DONE→DONE, writing the fixed results on the accepting edge.
  - valid rises at t+1.
  - Case detection is combinational on the raw inputs during the accept cycle.
- DIV_FASTPATH_EN undefined: these cases take the normal WIDTH+1 latency. Result values and error are identical in both builds.

## Test plan
- WIDTH=32, unsigned 100 / 7 -> quotient=14, remainder=2, error=0, valid exactly at cycle 33 after start.
- WIDTH=32, signed -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); signed 7 / -2 -> quotient=-3, remainder=1.
- WIDTH=32, 7 / 0 (both is_signed values) -> quotient=0xFFFFFFFF, remainder=7, error=1. Latency 1 with DIV_FASTPATH_EN, 33 without.
- WIDTH=32, signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, error=0. Unsigned same operands -> quotient=0, remainder=0x80000000.
- Reset pulse during CALC (cycle 10) -> ready=1, valid never pulses, outputs=0. Then start held high for two requests -> back-to-back valid pulses 33 cycles apart, and start during CALC ignored.
- WIDTH=8, exhaustive 256×256 signed and unsigned compare against the reference model, latency 9.

Source files
------------

// File: rtl/div_iter_param.sv
// Iterative radix-2 restoring divider, WIDTH-bit, signed/unsigned, RISC-V M-extension corner cases.
// Define DIV_FASTPATH_EN to finish divide-by-zero and signed overflow in a single cycle.
module div_iter_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_valid,
  output logic             o_error,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;
  logic             r_valid;
  logic             r_error;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_accept;
  logic             w_dd_neg;
  logic             w_dv_neg;
  logic             w_dv_zero;
  logic [WIDTH-1:0] w_dd_mag;
  logic [WIDTH-1:0] w_dv_mag;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_quo;
  logic [WIDTH-1:0] w_fast_rem;

  assign w_accept  = i_start & (r_state != S_CALC);
  assign w_dd_neg  = i_is_signed & i_dividend[WIDTH-1];
  assign w_dv_neg  = i_is_signed & i_divisor[WIDTH-1];
  assign w_dv_zero = (i_divisor == '0);
  // Most-negative value negates to itself, which is the correct unsigned magnitude 2^(WIDTH-1).
  assign w_dd_mag  = w_dd_neg ? ('0 - i_dividend) : i_dividend;
  assign w_dv_mag  = w_dv_neg ? ('0 - i_divisor) : i_divisor;

`ifdef DIV_FASTPATH_EN
  logic w_ovf;
  assign w_ovf      = i_is_signed & (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (i_divisor == '1);
  assign w_fast     = w_dv_zero | w_ovf;
  assign w_fast_quo = w_dv_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
  assign w_fast_rem = w_dv_zero ? i_dividend : '0;
`else
  assign w_fast     = 1'b0;
  assign w_fast_quo = '0;
  assign w_fast_rem = '0;
`endif

  // One restoring step: shift {rem, quo} left, subtract divisor when it fits.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_rem_step = w_ge ? WIDTH'(w_shift - {1'b0, r_dvs}) : w_shift[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_res    = r_q_neg ? ('0 - w_quo_step) : w_quo_step;
  assign w_r_res    = r_r_neg ? ('0 - w_rem_step) : w_rem_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) w_state_nxt = w_fast ? S_DONE : S_CALC;
        else         w_state_nxt = S_IDLE;
      end
      S_CALC:  if (r_cnt == '0) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dz        <= 1'b0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_rem   <= '0;
        r_quo   <= w_dd_mag;
        r_dvs   <= w_dv_mag;
        r_q_neg <= i_is_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]) & ~w_dv_zero;
        r_r_neg <= w_dd_neg;
        r_dz    <= w_dv_zero;
        r_cnt   <= CW'(WIDTH - 1);
        if (w_fast) begin
          r_quotient  <= w_fast_quo;
          r_remainder <= w_fast_rem;
          r_error     <= w_dv_zero;
        end
      end else if (r_state == S_CALC) begin
        r_rem <= w_rem_step;
        r_quo <= w_quo_step;
        if (r_cnt == '0) begin
          r_quotient  <= w_q_res;
          r_remainder <= w_r_res;
          r_error     <= r_dz;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign o_ready     = (r_state != S_CALC);
  assign o_valid     = r_valid;
  assign o_error     = r_error;
  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;

endmodule
